cfg_mib_master: RTL and testbench
=================================

// Module: cfg_mib_master
// PURPOSE
//  Command-to-MIB bridge inside cfg: takes one 32-bit read/write command from the FMC slave
//  (sel/rd_wr_n/addr/wdata, level sel held until ack) and runs it as a 16-bit MIB bus
//  transaction to the mib_slave_wrapper on each FPGA. Returns read data, ack and a timeout
//  flag to the FMC slave. MIB tri-state buffer lives at cfg_top; this block drives dout/oe.
// PARAMETERS
//  ADDR_BITS        24            MIB address width; [23:20] = slave MSN
//  ACK_TIMEOUT_CLKS 32            WAIT_ACK clocks before timeout; must exceed slave P_CMD_ACK_TIMEOUT_CLKS (16)
//  TURN_CLKS        1             bus-release clocks between master drive and slave ack window (>=1)
//  TIMEOUT_RDATA    32'hDEADDEAD  o_cmd_rdata value returned on timeout
// PORTS
//  i_sysclk         in   1   system clock
//  i_arst_n         in   1   asynchronous active-low reset
//  i_cmd_sel        in   1   command request, level, held until o_cmd_ack
//  i_cmd_rd_wr_n    in   1   1=read 0=write
//  i_cmd_addr       in   24  MIB word address
//  i_cmd_wdata      in   32  write data
//  o_cmd_ack        out  1   one-cycle completion pulse
//  o_cmd_rdata      out  32  read data, valid while o_cmd_ack=1, held until next ack
//  o_cmd_timeout    out  1   one-cycle pulse coincident with o_cmd_ack when no slave ack
//  o_mib_start      out  1   high for first address cycle only
//  o_mib_rd_wr_n    out  1   direction, valid from start until return to IDLE
//  o_mib_dout       out  16  master drive data
//  o_mib_d_oe       out  1   1=master drives MIB dabus
//  i_mib_din        in   16  dabus sampled value
//  i_mib_slave_ack  in   1   slave ack (any slave)
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, o_cmd_rdata=0, state IDLE, oe dropped at once.
//  All outputs registered. Accept on rising edge of i_cmd_sel (sel=1, sel_q=0) in IDLE only;
//   latch addr/wdata/rd_wr_n. Sel held high after ack never starts a 2nd transaction.
//  States (one clock each unless noted; dout/oe shown are values during that state):
//   IDLE     oe=0; on accept -> AHI
//   AHI      start=1 oe=1 dout={8'h00,addr[23:16]} -> ALO
//   ALO      oe=1 dout=addr[15:0] -> write: WHI, read: TURN
//   WHI      oe=1 dout=wdata[31:16] -> WLO
//   WLO      oe=1 dout=wdata[15:0] -> TURN
//   TURN     oe=0 for TURN_CLKS clocks -> WAIT (counter cleared)
//   WAIT     count clocks; ack sampled: write -> DONE; read -> rdata[31:16]=din, -> RLO
//            count==ACK_TIMEOUT_CLKS with no ack -> DONE, timeout=1, rdata=TIMEOUT_RDATA
//   RLO      rdata[15:0]=din (slave drives low half the clock after ack) -> DONE
//   DONE     o_cmd_ack=1 (+o_cmd_timeout if timed out) -> IDLE
//  Latency: accept edge N -> start in N+1. Write: 4 drive + TURN_CLKS + wait; ack at edge M
//   -> o_cmd_ack in M+1 (write), M+2 (read).
//  Boundaries: ack outside WAIT ignored (incl. stuck-high ack in IDLE); ack on same edge
//   count hits limit -> ack wins, no timeout; sel dropped mid-transaction -> transaction still
//   completes and acks; counter width $clog2(ACK_TIMEOUT_CLKS+1), never wraps; oe never 1 in
//   TURN/WAIT/RLO (no contention with slave).
// CONFIGURATION
//  CFG_MIB_MASTER_STATS_EN defined: adds o_txn_count[15:0] (+1 per DONE) and
//   o_timeout_count[15:0] (+1 per timed-out DONE), both saturate at 16'hFFFF, reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  Write addr 0x000000 data 0xDEADBEEF, slave acks 3 clk into WAIT -> start 1 clk, dout
//   0x0000,0x0000,0xDEAD,0xBEEF with oe=1, oe=0 from TURN; cmd_ack 1 clk after ack, timeout=0.
//  Read addr 0x100004, slave ack with din 0xCAFE then 0xBABE -> dout 0x0010,0x0004;
//   o_cmd_rdata=0xCAFEBABE with ack 2 clks after slave ack.
//  Read, no slave ack -> ack+timeout pulse 32 clks into WAIT, rdata=0xDEADDEAD.
//  Slave ack pulsed during AHI/ALO, and held high in IDLE -> ignored; real ack later completes.
//  i_arst_n low mid-WAIT -> oe/start/ack 0 immediately; after release, sel still high -> no txn
//   until sel toggles low->high.
//  STATS_EN: 3 good + 2 timed-out txns -> txn_count=5, timeout_count=2.

Source files
------------

// File: rtl/cfg_mib_master.sv
// cfg_mib_master: runs one 32-bit FMC read/write command as a 16-bit MIB bus transaction.
// Optional CFG_MIB_MASTER_STATS_EN adds saturating o_txn_count / o_timeout_count outputs.
module cfg_mib_master #(
    parameter int unsigned ADDR_BITS        = 24,
    parameter int unsigned ACK_TIMEOUT_CLKS = 32,
    parameter int unsigned TURN_CLKS        = 1,
    parameter logic [31:0] TIMEOUT_RDATA    = 32'hDEADDEAD
) (
    input  logic                 i_sysclk,
    input  logic                 i_arst_n,
    input  logic                 i_cmd_sel,
    input  logic                 i_cmd_rd_wr_n,
    input  logic [ADDR_BITS-1:0] i_cmd_addr,
    input  logic [31:0]          i_cmd_wdata,
    output logic                 o_cmd_ack,
    output logic [31:0]          o_cmd_rdata,
    output logic                 o_cmd_timeout,
    output logic                 o_mib_start,
    output logic                 o_mib_rd_wr_n,
    output logic [15:0]          o_mib_dout,
    output logic                 o_mib_d_oe,
    input  logic [15:0]          i_mib_din,
    input  logic                 i_mib_slave_ack
`ifdef CFG_MIB_MASTER_STATS_EN
    ,
    output logic [15:0]          o_txn_count,
    output logic [15:0]          o_timeout_count
`endif
);

    localparam int unsigned CNT_MAX = (ACK_TIMEOUT_CLKS > TURN_CLKS) ? ACK_TIMEOUT_CLKS : TURN_CLKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TURN_LIM = CNT_W'(TURN_CLKS);
    localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT_CLKS);

    typedef enum logic [3:0] {
        S_IDLE, S_AHI, S_ALO, S_WHI, S_WLO, S_TURN, S_WAIT, S_RLO, S_DONE
    } state_t;

    state_t               state, state_nx;
    logic                 sel_q;
    logic                 accept;
    logic [ADDR_BITS-1:0] addr_q, addr_nx;
    logic [31:0]          wdata_q, wdata_nx;
    logic                 rw_q, rw_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx, cnt_inc;
    logic [15:0]          rd_hi, rd_hi_nx;
    logic [31:0]          rdata_nx;
    logic [31:0]          addr_ext;
    logic                 start_nx, oe_nx, ack_nx, timeout_nx, mib_rw_nx;
    logic [15:0]          dout_nx;

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        state_nx   = state;
        addr_nx    = addr_q;
        wdata_nx   = wdata_q;
        rw_nx      = rw_q;
        cnt_nx     = cnt;
        rd_hi_nx   = rd_hi;
        rdata_nx   = o_cmd_rdata;
        timeout_nx = 1'b0;
        cnt_inc    = cnt + 1'b1;
        accept     = i_cmd_sel & ~sel_q & (state == S_IDLE);

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_AHI;
                    addr_nx  = i_cmd_addr;
                    wdata_nx = i_cmd_wdata;
                    rw_nx    = i_cmd_rd_wr_n;
                end
            end
            S_AHI: state_nx = S_ALO;
            S_ALO: begin
                state_nx = rw_q ? S_TURN : S_WHI;
                cnt_nx   = '0;
            end
            S_WHI: state_nx = S_WLO;
            S_WLO: begin
                state_nx = S_TURN;
                cnt_nx   = '0;
            end
            S_TURN: begin
                if (cnt_inc == TURN_LIM) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            S_WAIT: begin
                // A slave ack on the final counted clock takes priority over the timeout.
                if (i_mib_slave_ack) begin
                    if (rw_q) begin
                        rd_hi_nx = i_mib_din;
                        state_nx = S_RLO;
                    end else begin
                        state_nx = S_DONE;
                    end
                end else if (cnt_inc == ACK_LIM) begin
                    state_nx   = S_DONE;
                    timeout_nx = 1'b1;
                    rdata_nx   = TIMEOUT_RDATA;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            S_RLO: begin
                rdata_nx = {rd_hi, i_mib_din};
                state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        addr_ext  = 32'(addr_nx);
        start_nx  = (state_nx == S_AHI);
        ack_nx    = (state_nx == S_DONE);
        mib_rw_nx = (state_nx != S_IDLE) & rw_nx;
        oe_nx     = 1'b0;
        dout_nx   = '0;
        case (state_nx)
            S_AHI: begin oe_nx = 1'b1; dout_nx = addr_ext[31:16]; end
            S_ALO: begin oe_nx = 1'b1; dout_nx = addr_ext[15:0];  end
            S_WHI: begin oe_nx = 1'b1; dout_nx = wdata_nx[31:16]; end
            S_WLO: begin oe_nx = 1'b1; dout_nx = wdata_nx[15:0];  end
            default: ;
        endcase
    end

    // sel_q resets high so a sel already asserted across reset release is not taken as an edge.
    always_ff @(posedge i_sysclk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state         <= S_IDLE;
            sel_q         <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            rw_q          <= 1'b0;
            cnt           <= '0;
            rd_hi         <= '0;
            o_cmd_ack     <= 1'b0;
            o_cmd_rdata   <= '0;
            o_cmd_timeout <= 1'b0;
            o_mib_start   <= 1'b0;
            o_mib_rd_wr_n <= 1'b0;
            o_mib_dout    <= '0;
            o_mib_d_oe    <= 1'b0;
        end else begin
            state         <= state_nx;
            sel_q         <= i_cmd_sel;
            addr_q        <= addr_nx;
            wdata_q       <= wdata_nx;
            rw_q          <= rw_nx;
            cnt           <= cnt_nx;
            rd_hi         <= rd_hi_nx;
            o_cmd_ack     <= ack_nx;
            o_cmd_rdata   <= rdata_nx;
            o_cmd_timeout <= timeout_nx;
            o_mib_start   <= start_nx;
            o_mib_rd_wr_n <= mib_rw_nx;
            o_mib_dout    <= dout_nx;
            o_mib_d_oe    <= oe_nx;
        end
    end

`ifdef CFG_MIB_MASTER_STATS_EN
    always_ff @(posedge i_sysclk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_txn_count     <= '0;
            o_timeout_count <= '0;
        end else begin
            if (ack_nx && (o_txn_count != 16'hFFFF))
                o_txn_count <= o_txn_count + 16'd1;
            if (timeout_nx && (o_timeout_count != 16'hFFFF))
                o_timeout_count <= o_timeout_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cfg_mib_master.sv
// Testbench for cfg_mib_master: transaction-level expected trace per command, checked every cycle.
// Build with CFG_MIB_MASTER_STATS_EN defined to also check the statistics counters.
module tb_cfg_mib_master;

    localparam int unsigned ACK_TO   = 32;
    localparam int unsigned TURN     = 1;
    localparam logic [31:0] TO_RDATA = 32'hDEADDEAD;

    logic        tb_sys_clk = 1'b0;
    logic        arst_n     = 1'b0;
    logic        cmd_sel    = 1'b0;
    logic        cmd_rd_wr_n = 1'b0;
    logic [23:0] cmd_addr   = '0;
    logic [31:0] cmd_wdata  = '0;
    logic        cmd_ack;
    logic [31:0] cmd_rdata;
    logic        cmd_timeout;
    logic        mib_start;
    logic        mib_rd_wr_n;
    logic [15:0] mib_dout;
    logic        mib_d_oe;
    logic [15:0] mib_din    = '0;
    logic        mib_slave_ack = 1'b0;
`ifdef CFG_MIB_MASTER_STATS_EN
    logic [15:0] txn_count;
    logic [15:0] timeout_count;
`endif

    always #5 tb_sys_clk = ~tb_sys_clk;

    cfg_mib_master #(
        .ADDR_BITS(24),
        .ACK_TIMEOUT_CLKS(ACK_TO),
        .TURN_CLKS(TURN),
        .TIMEOUT_RDATA(TO_RDATA)
    ) dut (
        .i_sysclk(tb_sys_clk),
        .i_arst_n(arst_n),
        .i_cmd_sel(cmd_sel),
        .i_cmd_rd_wr_n(cmd_rd_wr_n),
        .i_cmd_addr(cmd_addr),
        .i_cmd_wdata(cmd_wdata),
        .o_cmd_ack(cmd_ack),
        .o_cmd_rdata(cmd_rdata),
        .o_cmd_timeout(cmd_timeout),
        .o_mib_start(mib_start),
        .o_mib_rd_wr_n(mib_rd_wr_n),
        .o_mib_dout(mib_dout),
        .o_mib_d_oe(mib_d_oe),
        .i_mib_din(mib_din),
        .i_mib_slave_ack(mib_slave_ack)
`ifdef CFG_MIB_MASTER_STATS_EN
        ,
        .o_txn_count(txn_count),
        .o_timeout_count(timeout_count)
`endif
    );

    typedef struct packed {
        logic        start;
        logic        oe;
        logic        rw;
        logic        ack;
        logic        to;
        logic [15:0] dout;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_cur;
    int unsigned n_run  = 0;
    int unsigned n_fail = 0;
    bit          chk_en = 1'b0;
    logic [31:0] exp_rdata = '0;
    int          cyc_idx = 0;
    int          ack_idx = -1;
    logic [31:0] seen_rdata = '0;
    logic        seen_to = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic st, input logic oe, input logic [15:0] d,
                                input logic rw, input logic ak, input logic to,
                                input logic [31:0] rd);
        exp_t e;
        e.start = st; e.oe = oe; e.dout = d; e.rw = rw; e.ack = ak; e.to = to; e.rdata = rd;
        return e;
    endfunction

    always @(negedge tb_sys_clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                e_cur = exp_q.pop_front();
                check("start", 32'(mib_start), 32'(e_cur.start));
                check("oe", 32'(mib_d_oe), 32'(e_cur.oe));
                check("rd_wr_n", 32'(mib_rd_wr_n), 32'(e_cur.rw));
                check("cmd_ack", 32'(cmd_ack), 32'(e_cur.ack));
                check("timeout", 32'(cmd_timeout), 32'(e_cur.to));
                if (e_cur.oe) check("dout", 32'(mib_dout), 32'(e_cur.dout));
                if (e_cur.ack) begin
                    check("rdata", cmd_rdata, e_cur.rdata);
                    exp_rdata  = e_cur.rdata;
                    ack_idx    = cyc_idx;
                    seen_rdata = cmd_rdata;
                    seen_to    = cmd_timeout;
                end
                cyc_idx++;
            end else begin
                check("idle_start", 32'(mib_start), 32'd0);
                check("idle_oe", 32'(mib_d_oe), 32'd0);
                check("idle_ack", 32'(cmd_ack), 32'd0);
                check("idle_timeout", 32'(cmd_timeout), 32'd0);
                check("idle_rdata", cmd_rdata, exp_rdata);
            end
        end
    end

    // k: WAIT clock (0-based) in which the slave acks; negative or >= ACK_TO means no ack.
    task automatic run_cmd(input logic rw, input logic [23:0] addr, input logic [31:0] wd,
                           input int k, input logic [15:0] hi, input logic [15:0] lo,
                           input bit spur, input bit drop_early);
        int  w0;
        int  nwait;
        bit  acked;
        logic [31:0] fin;
        @(posedge tb_sys_clk); #1;
        cmd_sel = 1'b1; cmd_rd_wr_n = rw; cmd_addr = addr; cmd_wdata = wd;
        @(posedge tb_sys_clk); #1;
        cyc_idx = 0; ack_idx = -1;
        acked = (k >= 0) && (k < int'(ACK_TO));
        nwait = acked ? k + 1 : int'(ACK_TO);
        fin   = !acked ? TO_RDATA : (rw ? {hi, lo} : exp_rdata);
        exp_q.push_back(mk(1'b1, 1'b1, {8'h00, addr[23:16]}, rw, 1'b0, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b1, addr[15:0], rw, 1'b0, 1'b0, 32'h0));
        if (!rw) begin
            exp_q.push_back(mk(1'b0, 1'b1, wd[31:16], rw, 1'b0, 1'b0, 32'h0));
            exp_q.push_back(mk(1'b0, 1'b1, wd[15:0], rw, 1'b0, 1'b0, 32'h0));
        end
        for (int i = 0; i < int'(TURN) + nwait; i++)
            exp_q.push_back(mk(1'b0, 1'b0, 16'h0, rw, 1'b0, 1'b0, 32'h0));
        if (rw && acked) exp_q.push_back(mk(1'b0, 1'b0, 16'h0, rw, 1'b0, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 16'h0, rw, 1'b1, !acked, fin));

        if (spur) begin mib_slave_ack = 1'b1; mib_din = 16'h1234; end
        @(posedge tb_sys_clk); #1;
        if (drop_early) cmd_sel = 1'b0;
        @(posedge tb_sys_clk); #1;
        mib_slave_ack = 1'b0; mib_din = 16'h0;
        if (acked) begin
            w0 = (rw ? 2 : 4) + int'(TURN);
            repeat (w0 + k - 2) @(posedge tb_sys_clk);
            #1; mib_slave_ack = 1'b1; mib_din = hi;
            @(posedge tb_sys_clk); #1;
            mib_slave_ack = 1'b0; mib_din = lo;
            @(posedge tb_sys_clk); #1;
            mib_din = 16'h0;
        end
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge tb_sys_clk);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1 cmd_sel = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge tb_sys_clk);
        #1;
        check("rst_oe", 32'(mib_d_oe), 32'd0);
        check("rst_start", 32'(mib_start), 32'd0);
        check("rst_ack", 32'(cmd_ack), 32'd0);
        check("rst_rdata", cmd_rdata, 32'd0);
        @(negedge tb_sys_clk); #2 arst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge tb_sys_clk);

        // Write 0x000000 <- 0xDEADBEEF, slave ack 3 clocks into WAIT
        run_cmd(1'b0, 24'h000000, 32'hDEADBEEF, 3, 16'h0, 16'h0, 1'b0, 1'b0);
        check("wr_ack_cycle", 32'(ack_idx), 32'd9);
        check("wr_timeout", 32'(seen_to), 32'd0);

        // Read 0x100004, slave returns 0xCAFE then 0xBABE
        run_cmd(1'b1, 24'h100004, 32'h0, 2, 16'hCAFE, 16'hBABE, 1'b0, 1'b0);
        check("rd_ack_cycle", 32'(ack_idx), 32'd7);
        check("rd_rdata", seen_rdata, 32'hCAFEBABE);

        // Read with no slave ack
        run_cmd(1'b1, 24'h0A0B0C, 32'h0, -1, 16'h0, 16'h0, 1'b0, 1'b0);
        check("to_ack_cycle", 32'(ack_idx), 32'd35);
        check("to_flag", 32'(seen_to), 32'd1);
        check("to_rdata", seen_rdata, 32'hDEADDEAD);

        // Stuck-high ack in IDLE, then spurious ack in AHI/ALO before the real ack
        @(posedge tb_sys_clk); #1 mib_slave_ack = 1'b1;
        repeat (6) @(posedge tb_sys_clk);
        #1 mib_slave_ack = 1'b0;
        run_cmd(1'b1, 24'h3F0101, 32'h0, 5, 16'h1357, 16'h9BDF, 1'b1, 1'b0);
        check("spur_rdata", seen_rdata, 32'h13579BDF);

        // Ack on the last counted WAIT clock beats the timeout
        run_cmd(1'b1, 24'hFFFFFF, 32'h0, 31, 16'hA5A5, 16'h5A5A, 1'b0, 1'b0);
        check("edge_ack_cycle", 32'(ack_idx), 32'd36);
        check("edge_timeout", 32'(seen_to), 32'd0);

        // Reset mid-WAIT, sel held through release
        chk_en = 1'b0;
        @(posedge tb_sys_clk); #1;
        cmd_sel = 1'b1; cmd_rd_wr_n = 1'b1; cmd_addr = 24'h2ABCDE;
        repeat (6) @(posedge tb_sys_clk);
        #2 arst_n = 1'b0;
        #1;
        check("arst_oe", 32'(mib_d_oe), 32'd0);
        check("arst_start", 32'(mib_start), 32'd0);
        check("arst_ack", 32'(cmd_ack), 32'd0);
        check("arst_timeout", 32'(cmd_timeout), 32'd0);
        check("arst_rdata", cmd_rdata, 32'd0);
        exp_rdata = '0;
        repeat (2) @(posedge tb_sys_clk);
        @(negedge tb_sys_clk); #2 arst_n = 1'b1;
        chk_en = 1'b1;
        repeat (6) @(posedge tb_sys_clk);
        #1 cmd_sel = 1'b0;

        // Three good and two timed-out transactions after reset
        run_cmd(1'b0, 24'h123456, 32'h01234567, 0, 16'h0, 16'h0, 1'b0, 1'b1);
        run_cmd(1'b1, 24'h0F00F0, 32'h0, 4, 16'h8765, 16'h4321, 1'b0, 1'b0);
        check("post_rdata", seen_rdata, 32'h87654321);
        run_cmd(1'b0, 24'h800001, 32'hFEDCBA98, 1, 16'h0, 16'h0, 1'b0, 1'b0);
        run_cmd(1'b1, 24'h000010, 32'h0, -1, 16'h0, 16'h0, 1'b0, 1'b0);
        run_cmd(1'b0, 24'h000020, 32'h55AA55AA, -1, 16'h0, 16'h0, 1'b0, 1'b0);
        check("wr_to_ack_cycle", 32'(ack_idx), 32'd37);
        check("wr_to_rdata", seen_rdata, 32'hDEADDEAD);
`ifdef CFG_MIB_MASTER_STATS_EN
        check("txn_count", 32'(txn_count), 32'd5);
        check("timeout_count", 32'(timeout_count), 32'd2);
`endif
        repeat (3) @(posedge tb_sys_clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
